hazard_ctrl_param: RTL

Parametrised successor to the pipeline hazard detector. Compares the source register addresses of the instruction in IF/ID against the destinations of in-flight instructions in the NUM_STAGES downstream stages. On a read-after-write hazard it inserts a counted number of bubbles using a stall FSM. The FSM is frozen by memory stalls and aborted by branch flushes. Sits beside the decode stage; drives the IF/ID hold, the ID/EX bubble insert and the global pipeline freeze.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_match.sv | 27 ++
 rtl/hazard_ctrl_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the parametrised hazard controller.
// State encoding, a constant-foldable ceil(log2) and a lowest-set-bit isolator.
package hazard_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = 32'(i + 1);
            end
        end
        return result;
    endfunction

    // Keeps only the least significant set bit (two's-complement trick).
    function automatic logic [31:0] onehot_lowest(input logic [31:0] vec);
        return vec & (~vec + 32'd1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Single-stage RAW comparator: flags when a writing stage targets any source
// register actually read by the instruction in decode.
module hazard_match #(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned NUM_RD = 2
) (
    input  logic [NUM_RD*REG_AW-1:0] rd_addr_i,
    input  logic [NUM_RD-1:0]        rd_used_i,
    input  logic [REG_AW-1:0]        wr_addr_i,
    input  logic                     reg_write_i,
    output logic                     hit_o
);

    logic any_match;

    always_comb begin
        any_match = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_used_i[p] && (rd_addr_i[p*REG_AW +: REG_AW] == wr_addr_i)) begin
                any_match = 1'b1;
            end
        end
    end

    assign hit_o = reg_write_i & any_match;

endmodule

// File: rtl/hazard_ctrl_param.sv
// Decode-stage RAW hazard controller with a counted-bubble stall FSM.
// Optional macro HAZARD_FWD_EN: assume full forwarding, only load-use in ID/EX stalls (1 bubble).
module hazard_ctrl_param
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 3,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*REG_AW-1:0]     rd_addr,
    input  logic [NUM_RD-1:0]            rd_used,
    input  logic [NUM_STAGES*REG_AW-1:0] wr_addr_stg,
    input  logic [NUM_STAGES-1:0]        reg_write_stg,
    input  logic [NUM_STAGES-1:0]        load_stg,
    input  logic                         take_branch,
    input  logic                         mem_stall_instr,
    input  logic                         mem_stall_data,
    output logic                         stall_ctrl,
    output logic                         start_stall,
    output logic                         freeze,
    output logic [NUM_STAGES-1:0]        stall_src,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int unsigned RemW = clog2(NUM_STAGES + 1);
    localparam int unsigned IdxW = (NUM_STAGES > 1) ? clog2(NUM_STAGES) : 1;

    logic [NUM_STAGES-1:0] hit;
    logic [NUM_STAGES-1:0] qhit;
    logic                  any_qhit;
    logic [IdxW-1:0]       s_min;
    logic [RemW-1:0]       need;
    logic [31:0]           oh_ext;
    logic [NUM_STAGES-1:0] src_oh;
    logic                  unused_oh;

    hz_state_e             state_q, state_d;
    logic [RemW-1:0]       rem_q, rem_d;
    logic                  stall_q, stall_d;
    logic [NUM_STAGES-1:0] stall_src_q, stall_src_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                  stall_raw;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_match
        hazard_match #(
            .REG_AW (REG_AW),
            .NUM_RD (NUM_RD)
        ) u_match (
            .rd_addr_i   (rd_addr),
            .rd_used_i   (rd_used),
            .wr_addr_i   (wr_addr_stg[s*REG_AW +: REG_AW]),
            .reg_write_i (reg_write_stg[s]),
            .hit_o       (hit[s])
        );
    end

`ifdef HAZARD_FWD_EN
    logic unused_fwd;

    // With forwarding only a load still in ID/EX cannot supply its result in time.
    always_comb begin
        qhit    = '0;
        qhit[0] = hit[0] & load_stg[0];
    end

    assign need       = RemW'(1);
    assign unused_fwd = ^{load_stg, hit, s_min};
`else
    logic unused_load;

    assign qhit        = hit;
    assign need        = RemW'(NUM_STAGES) - RemW'(s_min);
    assign unused_load = ^load_stg;
`endif

    assign any_qhit = |qhit;

    // The nearest producer dictates the bubble count; older ones retire meanwhile.
    always_comb begin
        s_min = '0;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            if (qhit[s]) begin
                s_min = IdxW'(s);
            end
        end
    end

    assign oh_ext    = onehot_lowest(32'(qhit));
    assign src_oh    = oh_ext[NUM_STAGES-1:0];
    assign unused_oh = ^oh_ext[31:NUM_STAGES];

    assign freeze = ~(mem_stall_instr | mem_stall_data);

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        stall_src_d = stall_src_q;
        stall_raw   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall_raw = any_qhit;
                if (freeze) begin
                    if (any_qhit) begin
                        stall_src_d = src_oh;
                        rem_d       = need - RemW'(1);
                        if (need > RemW'(1)) begin
                            state_d = ST_STALL;
                        end
                    end else begin
                        stall_src_d = '0;
                    end
                end
            end
            ST_STALL: begin
                stall_raw = 1'b1;
                if (freeze) begin
                    rem_d = rem_q - RemW'(1);
                    if (rem_q == RemW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase

        // A taken branch flushes the dependent instruction, so the episode is moot.
        if (take_branch) begin
            stall_raw   = 1'b0;
            state_d     = ST_IDLE;
            rem_d       = '0;
            stall_src_d = '0;
        end
    end

    assign stall_ctrl  = stall_raw & rst;
    assign start_stall = stall_ctrl & ~stall_q & freeze;

    always_comb begin
        stall_d     = freeze ? stall_ctrl : stall_q;
        stall_cnt_d = stall_cnt_q;
        if (stall_ctrl && freeze && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            stall_q     <= 1'b0;
            stall_src_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_q     <= stall_d;
            stall_src_q <= stall_src_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_src = stall_src_q;
    assign stall_cnt = stall_cnt_q;

endmodule
